// File: rtl/fault_sched_ctrl.sv
// Fault-injection campaign scheduler: queues timed faults, issues them to the
// injector with a req/ack handshake, then requests a state dump at the finish cycle.
module fault_sched_ctrl #(
  parameter int DEPTH = 8,
  parameter int TGT_W = 6,
  parameter int BIT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_en,
  input  logic [31:0]      cfg_cycle,
  input  logic [TGT_W-1:0] cfg_target,
  input  logic [BIT_W-1:0] cfg_bit,
  output logic             cfg_full,
  input  logic [31:0]      finish_cycle,
  input  logic             dump_en,
  input  logic             start,
  output logic             busy,
  output logic [31:0]      cycle_count,
  output logic             inj_req,
  output logic [TGT_W-1:0] inj_target,
  output logic [BIT_W-1:0] inj_bit,
  input  logic             inj_ack,
  output logic             dump_req,
  input  logic             dump_ack,
  output logic             done,
  output logic             missed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_INJ, S_DUMP, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_q_cyc [DEPTH];
  logic [TGT_W-1:0]   r_q_tgt [DEPTH];
  logic [BIT_W-1:0]   r_q_bit [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_cycle_count, r_finish;
  logic               r_dump_en, r_fin_hit, r_missed;
  logic               r_inj_req, r_dump_req;
  logic [TGT_W-1:0]   r_inj_target;
  logic [BIT_W-1:0]   r_inj_bit;

  logic w_empty, w_full, w_busy, w_fin_now, w_push;
  logic w_pop, w_flush, w_issue, w_set_missed, w_start_go, w_fin_set;
  logic [31:0] w_head_cyc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_busy     = (r_state == S_RUN) || (r_state == S_INJ) || (r_state == S_DUMP);
  assign w_fin_now  = (r_cycle_count == r_finish);
  assign w_head_cyc = r_q_cyc[r_rd_ptr];
  assign w_push     = cfg_wr_en && !w_full && !w_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Finish is made sticky so a burst of missed-entry pops or a handshake
  // spanning the finish cycle cannot skip past it.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_issue      = 1'b0;
    w_set_missed = 1'b0;
    w_start_go   = 1'b0;
    w_fin_set    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_go  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_fin_set = w_fin_now;
        if (!w_empty && (w_head_cyc == r_cycle_count)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_INJ;
        end else if (!w_empty && (w_head_cyc < r_cycle_count)) begin
          w_pop        = 1'b1;
          w_set_missed = 1'b1;
        end else if (w_fin_now || r_fin_hit) begin
          w_state_nxt = r_dump_en ? S_DUMP : S_DONE;
          w_flush     = !r_dump_en;
        end
      end
      S_INJ: begin
        w_fin_set = w_fin_now;
        if (inj_ack) begin
          w_pop = 1'b1;
          if (w_fin_now || r_fin_hit) begin
            w_state_nxt = r_dump_en ? S_DUMP : S_DONE;
            w_flush     = !r_dump_en;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DUMP: begin
        if (dump_ack) begin
          w_flush     = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Queue control: flush overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_cyc[r_wr_ptr] <= cfg_cycle;
      r_q_tgt[r_wr_ptr] <= cfg_target;
      r_q_bit[r_wr_ptr] <= cfg_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_count <= '0;
      r_finish      <= '0;
      r_dump_en     <= 1'b0;
      r_fin_hit     <= 1'b0;
      r_missed      <= 1'b0;
      r_inj_req     <= 1'b0;
      r_dump_req    <= 1'b0;
      r_inj_target  <= '0;
      r_inj_bit     <= '0;
    end else begin
      r_inj_req  <= (w_state_nxt == S_INJ);
      r_dump_req <= (w_state_nxt == S_DUMP);
      if (w_issue) begin
        r_inj_target <= r_q_tgt[r_rd_ptr];
        r_inj_bit    <= r_q_bit[r_rd_ptr];
      end
      if (w_start_go) begin
        r_finish      <= finish_cycle;
        r_dump_en     <= dump_en;
        r_cycle_count <= '0;
        r_missed      <= 1'b0;
        r_fin_hit     <= 1'b0;
      end else begin
        if (w_busy)       r_cycle_count <= sat_inc(r_cycle_count);
        if (w_set_missed) r_missed      <= 1'b1;
        if (w_fin_set)    r_fin_hit     <= 1'b1;
      end
    end
  end

  assign cfg_full    = w_full;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign cycle_count = r_cycle_count;
  assign inj_req     = r_inj_req;
  assign inj_target  = r_inj_target;
  assign inj_bit     = r_inj_bit;
  assign dump_req    = r_dump_req;
  assign missed      = r_missed;

endmodule

// File: doc/fault_sched_ctrl.md
Name: fault_sched_ctrl

Overview:
- Synthesizable scheduler for fault-injection campaigns on the GPU core.
- Holds a queue of scheduled faults, each a cycle, a target ID and a bit index. Counts cycles from a start pulse and issues each fault to the injector datapath with a req/ack handshake.
- At a programmed finish cycle it requests a micro-architectural state dump, then reports done.
- Sits between the host/testbench configuration interface and the per-unit fault injectors.

Parameters:
- DEPTH, 8, number of fault-queue entries (power of 2, at least 2)
- TGT_W, 6, width of the injection target ID
- BIT_W, 10, width of the bit index within the target

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- cfg_wr_en  input  1  push one fault entry
- cfg_cycle  input  32  fault cycle of the pushed entry
- cfg_target  input  TGT_W  target ID of the pushed entry
- cfg_bit  input  BIT_W  bit index of the pushed entry
- cfg_full  output  1  queue holds DEPTH entries
- finish_cycle  input  32  cycle at which the campaign ends; sampled at start
- dump_en  input  1  request a dump at finish; sampled at start
- start  input  1  one-cycle pulse that begins a campaign
- busy  output  1  state is RUN, INJ or DUMP
- cycle_count  output  32  campaign cycle counter
- inj_req  output  1  fault issue request
- inj_target  output  TGT_W  target of the current request
- inj_bit  output  BIT_W  bit of the current request
- inj_ack  input  1  injector accepted the request
- dump_req  output  1  dump request
- dump_ack  input  1  dump complete
- done  output  1  campaign finished
- missed  output  1  sticky flag: at least one fault was skipped

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE and the queue empties.
  - All outputs go to 0: cycle_count, inj_req, inj_target, inj_bit, dump_req, done, missed, busy, cfg_full.
- Queue:
  - Synchronous FIFO with wrapping read/write pointers and a count field.
  - A cfg_wr_en while full is dropped; no state changes.
  - Pushes are accepted in any state.
  - Entries must be pushed in ascending cfg_cycle order.
- States: IDLE, RUN, INJ, DUMP, DONE.
- IDLE / DONE:
  - On start: latch finish_cycle and dump_en, clear cycle_count, missed and done, go to RUN.
  - done=1 is held in DONE until the next start.
- start while busy is ignored.
- cycle_count:
  - Increments by 1 every cycle in RUN, INJ and DUMP.
  - Saturates at 32'hFFFFFFFF.
  - Holds in IDLE and DONE.
- RUN, evaluated each cycle in this priority order:
  1. Queue non-empty and head.cycle == cycle_count: load inj_target/inj_bit from the head, set inj_req=1 on the next edge, go to INJ.
  2. Queue non-empty and head.cycle < cycle_count: pop the head, set missed=1, stay in RUN.
  3. cycle_count == finish latch: go to DUMP with dump_req=1 if the dump_en latch is set, else go to DONE.
- INJ:
  - inj_req, inj_target and inj_bit are held stable until the first cycle with inj_ack=1.
  - On that edge: deassert inj_req, pop the head, go to RUN.
  - If cycle_count equalled the finish latch at any point during INJ, set an internal finish_hit flag. After the ack, go straight to DUMP or DONE as in RUN step 3.
- inj_ack outside INJ is ignored.
- Faults whose cycle equals the finish cycle are injected before the finish action.
- Back-to-back faults:
  - A head whose cycle passed during a previous handshake is handled by RUN step 2 (counted as missed).
  - Minimum spacing between issued faults is therefore ack latency + 2 cycles.
- DUMP:
  - dump_req is held until dump_ack.
  - On the ack edge: dump_req=0, flush the queue, go to DONE.
- Entering DONE by either path flushes the remaining queue entries.
- Finish cycle 0 with an empty queue: RUN detects the match on its first cycle and moves on.
- Reset asserted mid-handshake drops inj_req/dump_req immediately (asynchronous).

Test Plan:
- Single fault:
  - Stimulus: push {cycle=5, tgt=3, bit=17}, finish=20, dump_en=1, start; inj_ack 2 cycles after req; dump_ack 1 cycle after req.
  - Required: inj_req rises when cycle_count=6 with tgt=3/bit=17 and falls after the ack. dump_req rises at cycle_count=21. done=1 after dump_ack. missed=0.
- Missed fault:
  - Stimulus: push cycles {4, 5}; inj_ack held low for 6 cycles.
  - Required: fault 4 issued; entry 5 popped without issue; missed=1.
- Full queue:
  - Stimulus: push DEPTH+1 entries.
  - Required: cfg_full=1 after the 8th push; the 9th is dropped; exactly 8 faults are issued in order.
- Finish during INJ:
  - Stimulus: fault at cycle 10, finish=11, inj_ack delayed 4 cycles, dump_en=0.
  - Required: no dump_req; done=1 immediately after inj_ack; remaining entries flushed (cfg_full=0, queue empty).
- Asynchronous reset mid-INJ:
  - Stimulus: assert rst low while inj_req=1.
  - Required: inj_req, busy and cycle_count go to 0 without waiting for a clock edge; a subsequent start runs cleanly from cycle 0.
- start while busy:
  - Stimulus: pulse start during RUN at cycle_count=7.
  - Required: no counter clear; campaign unaffected.
